// File: rtl/framebuffer_fetch.sv
// Prefetches 16-bit framebuffer words from SRAM into a small FIFO and hands them
// to the colour mapper one 8-bit pixel at a time, yielding the bus whenever grant is low.
module framebuffer_fetch #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [19:0] BASE_ADDR  = 20'd0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        bus_grant,
  input  logic [15:0] DATA_IN,
  input  logic        pix_pop,
  output logic        reading,
  output logic [19:0] ADDR,
  output logic [7:0]  pixel,
  output logic        pix_valid,
  output logic        ready,
  output logic        underflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [17:0]      TOTAL_WORDS = 18'(H_RES * V_RES / 2);
  localparam logic [OCC_W-1:0] DEPTH_OCC   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [17:0]      word_cnt;
  logic             vld_p1;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             byte_hi;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [15:0]      head;
  logic             accept_p0, push_p1, pop_ok, deq, can_issue;

  // Stage p0: read request and acceptance on the SRAM bus
  assign can_issue = (word_cnt < TOTAL_WORDS) && ((occ + OCC_W'(vld_p1)) < DEPTH_OCC);
  assign accept_p0 = reading && bus_grant;
  assign ADDR      = reading ? (BASE_ADDR + {2'b00, word_cnt}) : 20'd0;

  // Stage p1: returning word lands in the FIFO unless a new frame flushed it
  assign push_p1   = vld_p1 && !frame_start;
  assign pix_valid = (occ != '0);
  assign pop_ok    = pix_pop && pix_valid;
  assign deq       = pop_ok && byte_hi;
  assign head      = mem[rd_ptr];
  assign pixel     = pix_valid ? (byte_hi ? head[15:8] : head[7:0]) : 8'h00;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = IDLE;
      FILL: if (occ == DEPTH_OCC || (word_cnt == TOTAL_WORDS && !vld_p1)) state_nxt = RUN;
      RUN:  if (word_cnt == TOTAL_WORDS && !vld_p1 && occ == '0) state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = FILL;
  end

  always_comb begin
    reading = 1'b0;
    ready   = 1'b0;
    case (state)
      FILL: reading = can_issue;
      RUN: begin
        reading = can_issue;
        ready   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || frame_start) begin
      word_cnt  <= '0;
      vld_p1    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      byte_hi   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) word_cnt <= word_cnt + 18'd1;
      if (push_p1)   wr_ptr   <= wr_ptr + PTR_W'(1);
      if (deq)       rd_ptr   <= rd_ptr + PTR_W'(1);
      if (pop_ok)    byte_hi  <= !byte_hi;
      if (pix_pop && !pix_valid) underflow <= 1'b1;
      case ({push_p1, deq})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage carries data only; pointers and occupancy above decide what is live
  always_ff @(posedge Clk) begin
    if (push_p1) mem[wr_ptr] <= DATA_IN;
  end
endmodule

// File: tb/tb_framebuffer_fetch.sv
// Bench for framebuffer_fetch: a directed vector table plus a word-index scoreboard
// model checked every cycle on two instances (base 0 and a base that wraps past 20'hFFFFF).
module tb_framebuffer_fetch;
  localparam int NI = 2;
  localparam int H0 = 64, V0 = 32, H1 = 16, V1 = 4;
  localparam logic [19:0] B0 = 20'd0, B1 = 20'hFFFF8;
  localparam int DEPTH = 16;
  localparam int P_IDLE = 0, P_FILL = 1, P_RUN = 2, P_DONE = 3;

  logic Clk = 1'b0;
  logic Reset, frame_start, bus_grant;
  logic        pix_pop   [NI];
  logic [15:0] data_in   [NI];
  logic        reading   [NI];
  logic [19:0] addr      [NI];
  logic [7:0]  pixel     [NI];
  logic        pix_valid [NI];
  logic        ready     [NI];
  logic        underflow [NI];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    framebuffer_fetch #(
      .H_RES(g == 0 ? H0 : H1), .V_RES(g == 0 ? V0 : V1),
      .BASE_ADDR(g == 0 ? B0 : B1), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .bus_grant(bus_grant),
      .DATA_IN(data_in[g]), .pix_pop(pix_pop[g]), .reading(reading[g]), .ADDR(addr[g]),
      .pixel(pixel[g]), .pix_valid(pix_valid[g]), .ready(ready[g]), .underflow(underflow[g])
    );
  end

  // SRAM: returns the low half of the word address one cycle after an accepted read
  always @(posedge Clk) begin
    for (int g = 0; g < NI; g++)
      data_in[g] <= (reading[g] === 1'b1 && bus_grant) ? addr[g][15:0] : 16'($urandom);
  end

  int total = 0, bad = 0;
  int m_phase [NI], m_cnt [NI], m_size [NI], m_head [NI];
  bit m_hi [NI], m_infl [NI], m_uf [NI], m_live [NI];
  int d_acc [NI], d_pops [NI];
  bit d_edge [NI], d_top [NI], d_wrap [NI];
  logic [19:0] d_last [NI];

  typedef struct {
    int n; bit fs; bit gr; bit pop;
    bit e_rd; logic [19:0] e_addr; bit e_vld; logic [7:0] e_pix; bit e_rdy; bit e_uf;
  } vec_t;
  localparam int NV = 12;
  vec_t tbl [NV];

  function automatic int tot(int g);
    return (g == 0) ? H0 * V0 / 2 : H1 * V1 / 2;
  endfunction

  function automatic logic [19:0] base(int g);
    return (g == 0) ? B0 : B1;
  endfunction

  function automatic bit exp_reading(int g);
    return (m_phase[g] == P_FILL || m_phase[g] == P_RUN) && (m_cnt[g] < tot(g)) &&
           ((m_size[g] + int'(m_infl[g])) < DEPTH);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(int g);
    return {reading[g], addr[g], pixel[g], pix_valid[g], ready[g], underflow[g]};
  endfunction

  // Model: FIFO holds the consecutive frame words m_head .. m_head+m_size-1
  task automatic model_update(int g);
    bit acc;
    int nph;
    if (Reset) begin
      m_live[g] = 1; m_phase[g] = P_IDLE; m_cnt[g] = 0; m_size[g] = 0; m_head[g] = 0;
      m_hi[g] = 0; m_infl[g] = 0; m_uf[g] = 0;
      return;
    end
    if (!m_live[g]) return;
    acc = exp_reading(g) && bus_grant;
    nph = m_phase[g];
    if (m_phase[g] == P_FILL && (m_size[g] == DEPTH || (m_cnt[g] == tot(g) && !m_infl[g])))
      nph = P_RUN;
    if (m_phase[g] == P_RUN && m_cnt[g] == tot(g) && !m_infl[g] && m_size[g] == 0)
      nph = P_DONE;
    if (frame_start) begin
      nph = P_FILL;
      m_cnt[g] = 0; m_size[g] = 0; m_head[g] = 0; m_hi[g] = 0; m_uf[g] = 0; m_infl[g] = 0;
    end else begin
      if (pix_pop[g] === 1'b1) begin
        if (m_size[g] == 0) m_uf[g] = 1;
        else if (!m_hi[g]) m_hi[g] = 1;
        else begin m_head[g]++; m_size[g]--; m_hi[g] = 0; end
      end
      if (m_infl[g]) m_size[g]++;
      m_infl[g] = acc;
      if (acc) m_cnt[g]++;
    end
    m_phase[g] = nph;
  endtask

  task automatic model_check();
    logic [19:0] ea, ha;
    logic [7:0] ep;
    bit er;
    for (int g = 0; g < NI; g++) begin
      if (!m_live[g]) continue;
      er = exp_reading(g);
      ea = er ? base(g) + 20'(m_cnt[g]) : 20'd0;
      ha = base(g) + 20'(m_head[g]);
      ep = (m_size[g] == 0) ? 8'h00 : (m_hi[g] ? ha[15:8] : ha[7:0]);
      chk($sformatf("model%0d", g), outs(g),
          {er, ea, ep, m_size[g] != 0, m_phase[g] == P_RUN, m_uf[g]});
    end
  endtask

  task automatic observe();
    for (int g = 0; g < NI; g++) begin
      d_edge[g] = 0;
      if (Reset || frame_start) begin
        d_acc[g] = 0; d_pops[g] = 0; d_top[g] = 0; d_wrap[g] = 0; d_last[g] = 20'd0;
      end else begin
        if (reading[g] === 1'b1 && bus_grant) begin
          d_edge[g] = 1;
          d_acc[g]++;
          if (addr[g] == 20'h00000 && d_last[g] == 20'hFFFFF && d_acc[g] > 1) d_wrap[g] = 1;
          if (addr[g] == 20'hFFFFF) d_top[g] = 1;
          d_last[g] = addr[g];
        end
        if (pix_pop[g] === 1'b1 && pix_valid[g] === 1'b1) d_pops[g]++;
      end
    end
  endtask

  task automatic step();
    observe();
    for (int g = 0; g < NI; g++) model_update(g);
    @(posedge Clk);
    @(negedge Clk);
    model_check();
  endtask

  task automatic run_frame(string tag);
    for (int c = 0; c < 20000; c++) begin
      if (d_pops[0] == 2 * tot(0) && d_pops[1] == 2 * tot(1)) break;
      bus_grant = ($urandom % 4) != 0;
      for (int g = 0; g < NI; g++)
        pix_pop[g] = ready[g] && pix_valid[g] && (($urandom % 8) != 0);
      step();
    end
    for (int g = 0; g < NI; g++) pix_pop[g] = 1'b0;
    repeat (3) step();
    chk({tag, "_pops0"}, d_pops[0], 2 * tot(0));
    chk({tag, "_pops1"}, d_pops[1], 2 * tot(1));
    chk({tag, "_acc0"}, d_acc[0], tot(0));
    chk({tag, "_last0"}, d_last[0], 20'd1023);
    chk({tag, "_last1"}, d_last[1], 20'h00017);
    chk({tag, "_done0"}, {reading[0], ready[0], pix_valid[0], underflow[0]}, 4'b0000);
    chk({tag, "_done1"}, {reading[1], ready[1], pix_valid[1], underflow[1]}, 4'b0000);
  endtask

  initial begin
    //          n  fs gr pp  rd addr    vld pix    rdy uf
    tbl[0]  = '{1,  1, 1, 0, 1, 20'd0,  0, 8'h00, 0, 0};
    tbl[1]  = '{5,  0, 0, 0, 1, 20'd0,  0, 8'h00, 0, 0};
    tbl[2]  = '{1,  0, 1, 0, 1, 20'd1,  0, 8'h00, 0, 0};
    tbl[3]  = '{1,  0, 1, 0, 1, 20'd2,  1, 8'h00, 0, 0};
    tbl[4]  = '{1,  0, 0, 0, 1, 20'd2,  1, 8'h00, 0, 0};
    tbl[5]  = '{4,  0, 0, 0, 1, 20'd2,  1, 8'h00, 0, 0};
    tbl[6]  = '{14, 0, 1, 0, 0, 20'd0,  1, 8'h00, 0, 0};
    tbl[7]  = '{1,  0, 1, 0, 0, 20'd0,  1, 8'h00, 0, 0};
    tbl[8]  = '{1,  0, 1, 0, 0, 20'd0,  1, 8'h00, 1, 0};
    tbl[9]  = '{1,  0, 1, 1, 0, 20'd0,  1, 8'h00, 1, 0};
    tbl[10] = '{1,  0, 1, 1, 1, 20'd16, 1, 8'h01, 1, 0};
    tbl[11] = '{1,  0, 1, 1, 0, 20'd0,  1, 8'h00, 1, 0};

    Reset = 1'b1; frame_start = 1'b0; bus_grant = 1'b0;
    for (int g = 0; g < NI; g++) pix_pop[g] = 1'b0;
    step(); step();
    Reset = 1'b0;
    chk("reset0", outs(0), 32'h0);
    chk("reset1", outs(1), 32'h0);

    // Prefill, grant stalls and first pops, checked on the base-0 instance
    for (int i = 0; i < NV; i++) begin
      frame_start = tbl[i].fs;
      bus_grant   = tbl[i].gr;
      for (int g = 0; g < NI; g++) pix_pop[g] = tbl[i].pop;
      repeat (tbl[i].n) step();
      frame_start = 1'b0;
      chk($sformatf("vec%0d", i), outs(0),
          {tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_pix, tbl[i].e_vld, tbl[i].e_rdy, tbl[i].e_uf});
    end

    run_frame("frame1");
    chk("wrap1", {d_top[1], d_wrap[1]}, 2'b11);

    // Underflow: pops against an empty FIFO
    for (int g = 0; g < NI; g++) pix_pop[g] = 1'b1;
    repeat (3) step();
    chk("uf_set", {underflow[0], pix_valid[0], pixel[0]}, {1'b1, 1'b0, 8'h00});
    for (int g = 0; g < NI; g++) pix_pop[g] = 1'b0;
    step();
    chk("uf_hold", underflow[0], 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("uf_clear", {underflow[0], underflow[1], ready[0]}, 3'b000);

    // Mid-frame restart with a read in flight
    for (int c = 0; c < 20000; c++) begin
      bus_grant = 1'b1;
      for (int g = 0; g < NI; g++)
        pix_pop[g] = ready[g] && pix_valid[g] && (($urandom % 8) != 0);
      step();
      if (d_acc[0] == 500 && d_edge[0]) break;
    end
    chk("restart_reach", {d_acc[0], 31'b0, d_edge[0]}, {32'd500, 31'b0, 1'b1});
    for (int g = 0; g < NI; g++) pix_pop[g] = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("restart_flush", {pix_valid[0], ready[0], reading[0], addr[0]}, {1'b0, 1'b0, 1'b1, B0});
    step();
    chk("restart_addr", {d_acc[0], 12'h0, d_last[0]}, {32'd1, 12'h0, B0});
    chk("restart_drop", {pix_valid[0], ready[0]}, 2'b00);

    // Reset in the middle of a refill
    repeat (6) step();
    Reset = 1'b1;
    step();
    chk("midreset0", outs(0), 32'h0);
    chk("midreset1", outs(1), 32'h0);
    Reset = 1'b0;
    step();
    chk("postreset0", outs(0), 32'h0);

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    run_frame("frame2");
    chk("wrap2", {d_top[1], d_wrap[1]}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
